// File: rtl/text_write_ctrl.sv
// Text-mode write controller: accepts ASCII characters, maintains a
// cursor over a COLS x ROWS tile grid, and emits single-cycle writes to
// a character RAM. Also performs a full-screen clear with spaces.
module text_write_ctrl #(
  parameter int COLS = 39,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clr_req,
  output logic        busy,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [5:0]  cur_col,
  output logic [5:0]  cur_row
);

  localparam logic [5:0]  COL_MAX   = 6'(COLS - 1);
  localparam logic [5:0]  ROW_MAX   = 6'(ROWS - 1);
  localparam logic [10:0] LAST_ADDR = 11'(COLS * ROWS - 1);
  localparam logic [7:0]  CH_SPACE  = 8'h20;
  localparam logic [7:0]  CH_LF     = 8'h0A;
  localparam logic [7:0]  CH_CR     = 8'h0D;
  localparam logic [7:0]  CH_BS     = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [7:0]  char_q, char_d;
  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;

  // Linear RAM address of a tile; 11-bit product never truncates since
  // the grid holds at most 2048 cells.
  function automatic logic [10:0] cell_addr(input logic [5:0] row,
                                            input logic [5:0] col);
    logic [10:0] r;
    logic [10:0] c;
    r = 11'(row);
    c = 11'(col);
    return r * 11'(COLS) + c;
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  function automatic logic [5:0] next_row(input logic [5:0] row);
    return (row < ROW_MAX) ? row + 6'd1 : 6'd0;
  endfunction

  assign char_ready = (state_q == IDLE) && !clr_req && !rst;
  assign busy       = (state_q != IDLE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cur_col    = col_q;
  assign cur_row    = row_q;

  // Next-state and registered-output logic. The RAM strobe, address and
  // data are prepared at acceptance so the WRITE cycle drives them from
  // flops; the cursor moves at the end of WRITE.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    char_d    = char_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    clr_cnt_d = clr_cnt_q;

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = 11'd0;
          wr_data_d = CH_SPACE;
          clr_cnt_d = 11'd0;
        end else if (char_valid) begin
          state_d = WRITE;
          char_d  = char_in;
          if (is_printable(char_in)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(row_q, col_q);
            wr_data_d = char_in;
          end else if ((char_in == CH_BS) && (col_q != 6'd0)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(row_q, col_q - 6'd1);
            wr_data_d = CH_SPACE;
          end
        end
      end

      WRITE: begin
        state_d = IDLE;
        if (is_printable(char_q)) begin
          if (col_q < COL_MAX) begin
            col_d = col_q + 6'd1;
          end else begin
            col_d = 6'd0;
            row_d = next_row(row_q);
          end
        end else if (char_q == CH_LF) begin
          col_d = 6'd0;
          row_d = next_row(row_q);
        end else if (char_q == CH_CR) begin
          col_d = 6'd0;
        end else if ((char_q == CH_BS) && (col_q != 6'd0)) begin
          col_d = col_q - 6'd1;
        end
      end

      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = 11'd0;
          col_d     = 6'd0;
          row_d     = 6'd0;
        end else begin
          wr_en_d   = 1'b1;
          clr_cnt_d = clr_cnt_q + 11'd1;
          wr_addr_d = clr_cnt_q + 11'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any write or clear in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= 6'd0;
      row_q     <= 6'd0;
      char_q    <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 11'd0;
      wr_data_q <= 8'd0;
      clr_cnt_q <= 11'd0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      char_q    <= char_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl at the default 39x30 grid.
module tb_text_write_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        clr_req;
  logic        busy;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  cur_col;
  logic [5:0]  cur_row;

  int n_cmp = 0;
  int n_bad = 0;

  text_write_ctrl #(.COLS(39), .ROWS(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .clr_req   (clr_req),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cur_col   (cur_col),
    .cur_row   (cur_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one character, wait for its WRITE cycle, capture the strobe,
  // then return once the block is back in IDLE.
  task automatic send_char(input logic [7:0] c, output logic we,
                           output logic [10:0] a, output logic [7:0] d);
    int w;
    w = 0;
    char_in    = c;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && w < 3000) begin
      tick();
      w++;
    end
    if (w >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: char_ready=%b required 1", char_ready);
    end
    tick();
    char_valid = 1'b0;
    we = wr_en;
    a  = wr_addr;
    d  = wr_data;
    tick();
  endtask

  task automatic send_n(input logic [7:0] c, input int n);
    logic we;
    logic [10:0] a;
    logic [7:0] d;
    for (int i = 0; i < n; i++) send_char(c, we, a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1; char_valid = 1'b0; clr_req = 1'b0; char_in = 8'h00;
    tick(); tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 11'd0) begin n_bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({cur_col, cur_row} !== 12'd0) begin n_bad++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    n_cmp++; if (char_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", char_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (char_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", char_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    char_in = 8'h41; char_valid = 1'b1;
    tick();
    char_in = 8'h42;
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL b2b_a_en: got %b want 1", wr_en); end
    n_cmp++; if (wr_addr !== 11'd0) begin n_bad++; $display("FAIL b2b_a_addr: got %0d want 0", wr_addr); end
    n_cmp++; if (wr_data !== 8'h41) begin n_bad++; $display("FAIL b2b_a_data: got %h want 41", wr_data); end
    tick();
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_en: got %b want 0", wr_en); end
    n_cmp++; if (char_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_ready: got %b want 1", char_ready); end
    tick();
    char_valid = 1'b0;
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL b2b_b_en: got %b want 1", wr_en); end
    n_cmp++; if (wr_addr !== 11'd1) begin n_bad++; $display("FAIL b2b_b_addr: got %0d want 1", wr_addr); end
    n_cmp++; if (wr_data !== 8'h42) begin n_bad++; $display("FAIL b2b_b_data: got %h want 42", wr_data); end
    tick();
    n_cmp++; if (cur_col !== 6'd2 || cur_row !== 6'd0) begin n_bad++; $display("FAIL b2b_cursor: got (%0d,%0d) want (2,0)", cur_col, cur_row); end
  endtask

  task automatic test_line_wrap();
    logic we; logic [10:0] a; logic [7:0] d;
    send_char(8'h0D, we, a, d);
    n_cmp++; if (we !== 1'b0 || cur_col !== 6'd0 || cur_row !== 6'd0) begin n_bad++; $display("FAIL cr: got we=%b (%0d,%0d) want we=0 (0,0)", we, cur_col, cur_row); end
    send_n(8'h0A, 5);
    send_n(8'h20, 38);
    n_cmp++; if (cur_col !== 6'd38 || cur_row !== 6'd5) begin n_bad++; $display("FAIL pos_38_5: got (%0d,%0d) want (38,5)", cur_col, cur_row); end
    send_char(8'h5A, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 11'd233 || d !== 8'h5A) begin n_bad++; $display("FAIL eol_write: got we=%b addr=%0d data=%h want 1/233/5a", we, a, d); end
    n_cmp++; if (cur_col !== 6'd0 || cur_row !== 6'd6) begin n_bad++; $display("FAIL eol_cursor: got (%0d,%0d) want (0,6)", cur_col, cur_row); end
  endtask

  task automatic test_lf_wrap();
    logic we; logic [10:0] a; logic [7:0] d;
    send_n(8'h0A, 23);
    send_n(8'h20, 10);
    send_char(8'h0A, we, a, d);
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL lf_no_write: got %b want 0", we); end
    n_cmp++; if (a !== 11'd1140 || d !== 8'h20) begin n_bad++; $display("FAIL lf_hold: got addr=%0d data=%h want 1140/20", a, d); end
    n_cmp++; if (cur_col !== 6'd0 || cur_row !== 6'd0) begin n_bad++; $display("FAIL lf_wrap_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    send_char(8'h08, we, a, d);
    n_cmp++; if (we !== 1'b0 || cur_col !== 6'd0 || cur_row !== 6'd0) begin n_bad++; $display("FAIL bs_col0: got we=%b (%0d,%0d) want 0 (0,0)", we, cur_col, cur_row); end
  endtask

  task automatic test_backspace();
    logic we; logic [10:0] a; logic [7:0] d;
    send_n(8'h0A, 2);
    send_n(8'h20, 4);
    send_char(8'h08, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 11'd81 || d !== 8'h20) begin n_bad++; $display("FAIL bs_write: got we=%b addr=%0d data=%h want 1/81/20", we, a, d); end
    n_cmp++; if (cur_col !== 6'd3 || cur_row !== 6'd2) begin n_bad++; $display("FAIL bs_cursor: got (%0d,%0d) want (3,2)", cur_col, cur_row); end
    send_char(8'h01, we, a, d);
    n_cmp++; if (we !== 1'b0 || a !== 11'd81 || cur_col !== 6'd3 || cur_row !== 6'd2) begin n_bad++; $display("FAIL discard: got we=%b addr=%0d (%0d,%0d) want 0/81 (3,2)", we, a, cur_col, cur_row); end
  endtask

  task automatic test_bottom_wrap();
    logic we; logic [10:0] a; logic [7:0] d;
    send_n(8'h0A, 27);
    send_n(8'h20, 38);
    send_char(8'h7E, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 11'd1169 || d !== 8'h7E) begin n_bad++; $display("FAIL last_cell: got we=%b addr=%0d data=%h want 1/1169/7e", we, a, d); end
    n_cmp++; if (cur_col !== 6'd0 || cur_row !== 6'd0) begin n_bad++; $display("FAIL full_wrap: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    send_char(8'h7F, we, a, d);
    n_cmp++; if (we !== 1'b0 || cur_col !== 6'd0) begin n_bad++; $display("FAIL del_discard: got we=%b col=%0d want 0/0", we, cur_col); end
  endtask

  task automatic test_clear();
    int bad;
    int first;
    send_n(8'h20, 3);
    bad = 0; first = -1;
    clr_req = 1'b1; char_valid = 1'b1; char_in = 8'h51;
    #1;
    n_cmp++; if (char_ready !== 1'b0) begin n_bad++; $display("FAIL clr_prio_ready: got %b want 0", char_ready); end
    @(posedge clk); #1;
    clr_req = 1'b0; char_valid = 1'b0;
    for (int i = 0; i < 1170; i++) begin
      if (wr_en !== 1'b1 || wr_addr !== 11'(i) || wr_data !== 8'h20 || busy !== 1'b1) begin
        bad++;
        if (first < 0) first = i;
      end
      clr_req = (i == 600);
      tick();
    end
    clr_req = 1'b0;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clr_seq: %0d bad cycles, first at %0d, want 0", bad, first); end
    n_cmp++; if (wr_en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL clr_end: got wr_en=%b busy=%b want 0/0", wr_en, busy); end
    n_cmp++; if (cur_col !== 6'd0 || cur_row !== 6'd0) begin n_bad++; $display("FAIL clr_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    n_cmp++; if (char_ready !== 1'b1 || wr_addr !== 11'd1169) begin n_bad++; $display("FAIL clr_after: got ready=%b addr=%0d want 1/1169", char_ready, wr_addr); end
  endtask

  task automatic test_clr_after_write_and_reset();
    int w;
    int extra;
    logic we; logic [10:0] a; logic [7:0] d;
    char_in = 8'h43; char_valid = 1'b1;
    tick();
    char_valid = 1'b0; clr_req = 1'b1;
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h43) begin n_bad++; $display("FAIL cw_write: got %b/%0d/%h want 1/0/43", wr_en, wr_addr, wr_data); end
    tick();
    n_cmp++; if (busy !== 1'b0 || char_ready !== 1'b0 || wr_en !== 1'b0) begin n_bad++; $display("FAIL cw_idle: got busy=%b ready=%b en=%b want 0/0/0", busy, char_ready, wr_en); end
    tick();
    clr_req = 1'b0;
    n_cmp++; if (busy !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h20) begin n_bad++; $display("FAIL cw_clear: got busy=%b en=%b addr=%0d data=%h want 1/1/0/20", busy, wr_en, wr_addr, wr_data); end
    w = 0;
    while (wr_addr !== 11'd500 && w < 2000) begin tick(); w++; end
    n_cmp++; if (wr_addr !== 11'd500) begin n_bad++; $display("FAIL reach_500: got %0d want 500", wr_addr); end
    rst = 1'b1;
    tick();
    n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 11'd0 || wr_data !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_out: got %b/%0d/%h busy=%b want 0/0/00/0", wr_en, wr_addr, wr_data, busy); end
    n_cmp++; if (cur_col !== 6'd0 || cur_row !== 6'd0 || char_ready !== 1'b0) begin n_bad++; $display("FAIL abort_state: got (%0d,%0d) ready=%b want (0,0) 0", cur_col, cur_row, char_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (char_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", char_ready); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (wr_en !== 1'b0) extra++; end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL abort_no_pulse: got %0d pulses want 0", extra); end
    send_char(8'h41, we, a, d);
    n_cmp++; if (we !== 1'b1 || a !== 11'd0 || d !== 8'h41) begin n_bad++; $display("FAIL abort_then_a: got %b/%0d/%h want 1/0/41", we, a, d); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_lf_wrap();
    test_backspace();
    test_bottom_wrap();
    test_clear();
    test_clr_after_write_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_write_ctrl.md
TEXT_WRITE_CTRL -- requirements
Module: text_write_ctrl

Interface
REQ-001 Parameter COLS, default 39, tile columns per row; column index range 0..COLS-1.
REQ-002 Parameter ROWS, default 30, tile rows; row index range 0..ROWS-1; COLS*ROWS SHALL be at most 2048.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 char_in  in  8  ASCII code offered by the requester.
REQ-006 char_valid  in  1  char_in is valid.
REQ-007 char_ready  out  1  block accepts char_in this cycle.
REQ-008 clr_req  in  1  request to clear the whole screen.
REQ-009 busy  out  1  high whenever the state is not IDLE.
REQ-010 wr_en  out  1  one-cycle write strobe to the character RAM.
REQ-011 wr_addr  out  11  character RAM address, equal to row*COLS + col.
REQ-012 wr_data  out  8  character code written.
REQ-013 cur_col  out  6  current cursor column.
REQ-014 cur_row  out  6  current cursor row.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WRITE and CLEAR.
REQ-016 char_ready SHALL be high only in IDLE with clr_req low; a transfer occurs when char_valid and char_ready are both high.
REQ-017 In IDLE, clr_req high SHALL move the FSM to CLEAR; clr_req SHALL take priority over char_valid in the same cycle.
REQ-018 A transfer in cycle N SHALL latch char_in and move the FSM to WRITE in N+1; WRITE SHALL last one cycle and then return to IDLE, giving a maximum throughput of one character per 2 cycles.
REQ-019 Printable codes 0x20..0x7E: in the WRITE cycle, wr_en=1, wr_data=code, wr_addr=row*COLS+col using the cursor value held at acceptance, all driven from registers; then the cursor advances.
REQ-020 Advance rule: col<COLS-1 gives col+1; otherwise col=0 and the row advances.
REQ-021 Row advance rule: row<ROWS-1 gives row+1; otherwise row=0 (wrap to the top; no scrolling).
REQ-022 0x0A (LF): col=0, row advances per REQ-021, wr_en=0.
REQ-023 0x0D (CR): col=0, row unchanged, wr_en=0.
REQ-024 0x08 (BS), col>0: col=col-1, and a write of 0x20 occurs at the new position (row*COLS+col-1) in the WRITE cycle.
REQ-025 0x08 (BS), col=0: no cursor change, wr_en=0.
REQ-026 All other codes SHALL be discarded: they still take the WRITE cycle, with wr_en=0 and no cursor change.
REQ-027 In CLEAR, wr_en=1 every cycle, wr_data=0x20, and wr_addr SHALL step 0,1,...,COLS*ROWS-1, one address per cycle.
REQ-028 After the last address, the FSM SHALL return to IDLE in the next cycle with cursor (0,0); CLEAR lasts exactly COLS*ROWS cycles with wr_en high (1170 at the defaults).
REQ-029 clr_req asserted during CLEAR SHALL be ignored; clr_req held through WRITE SHALL be taken in the following IDLE cycle.
REQ-030 wr_en SHALL be 0 in IDLE and never high for more than one cycle per accepted character.
REQ-031 wr_addr and wr_data SHALL hold their last value when wr_en=0.
REQ-032 cur_col and cur_row SHALL reflect the registered cursor at all times.
REQ-033 The address multiply SHALL use 11-bit unsigned arithmetic with no truncation for all legal row/col values.

Reset
REQ-034 rst SHALL force on the next edge: state=IDLE, cursor (0,0), wr_en=0, wr_addr=0, wr_data=0, busy=0, char_ready=0 during the reset cycle, and the clear counter=0.
REQ-035 rst during WRITE or CLEAR SHALL abort the operation immediately, with no further wr_en pulses after the reset edge.
REQ-036 char_ready SHALL be high in the first cycle after rst deasserts if clr_req is low.

Verification
REQ-037 After reset, send 'A','B' (0x41,0x42) back-to-back -> wr_en pulses 2 cycles apart, at wr_addr 0 with 0x41 and wr_addr 1 with 0x42; cursor (2,0).
REQ-038 Cursor at (38,5), send 0x5A -> write at wr_addr 233; cursor becomes (0,6).
REQ-039 Cursor at (10,29), send 0x0A -> no write; cursor becomes (0,0); then 0x08 at (0,0) -> no write and no change.
REQ-040 Cursor at (4,2), send 0x08 -> write of 0x20 at wr_addr 81; cursor becomes (3,2).
REQ-041 Pulse clr_req together with char_valid in IDLE -> char not accepted; 1170 consecutive writes of 0x20 at addresses 0..1169; busy high throughout; cursor (0,0); char_ready high afterwards.
REQ-042 Assert rst at clear address 500 -> no wr_en after the reset edge; all outputs at reset values; a subsequent 'A' is written at wr_addr 0.
